seven_seg_scan_decoder: RTL and testbench
=========================================

SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: consecutive identical sampled cycles required before a digit is captured (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: cycles without a completed frame before stale asserts.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports an3, an2, an1, an0  in  1 each  active-low digit anodes under observation.
REQ-006 SHALL have ports led_a .. led_g  in  1 each  active-low segments; dp  in  1, ignored.
REQ-007 SHALL have ports char1, char2, char3, char4  out  4 each  recovered characters; char1 from an3, char4 from an0.
REQ-008 SHALL have port frame_valid  out  1  one-cycle pulse when char1..char4 update.
REQ-009 SHALL have ports seg_err and anode_err  out  1 each  one-cycle error pulses.
REQ-010 SHALL have port stale  out  1  level, no frame within TIMEOUT_CYCLES.

Function
REQ-011 SHALL register all anode and segment inputs once; all decisions use the registered copy (1 cycle input latency).
REQ-012 SHALL decode segment vector {a..g}, active-low, to hex 0x0-0xF using the team's standard 7-segment hex table; any other pattern is invalid.
REQ-013 SHALL implement FSM BLANK, SETTLING, HELD: BLANK when no anode low; any single anode low -> SETTLING with settle counter cleared.
REQ-014 SHALL, in SETTLING, return to SETTLING with counter cleared whenever the anode or segment vector changes; after SETTLE_CYCLES identical cycles -> HELD.
REQ-015 SHALL, on entering HELD with a valid pattern, write the decoded value to that digit's shadow register and set its seen bit; invalid pattern -> seg_err pulse, no write.
REQ-016 SHALL stay in HELD until the vector changes, then go to BLANK or SETTLING per REQ-013; no recapture while held.
REQ-017 SHALL, on more than one anode low, pulse anode_err once per entry into that condition and go to BLANK, discarding the settle count.
REQ-018 SHALL, in the cycle all four seen bits are set, copy shadows to char1..char4, pulse frame_valid the next cycle, and clear all seen bits.
REQ-019 SHALL treat recapture of an already-seen digit before frame completion as an overwrite of its shadow value.
REQ-020 SHALL hold char1..char4 constant between frame_valid pulses.

Reset
REQ-021 SHALL on reset set state BLANK, settle counter 0, seen bits 0, shadows 0, char1..char4 = 4'h0, frame_valid/seg_err/anode_err = 0, stale = 0, timeout counter 0.
REQ-022 SHALL, on reset asserted mid-settle or mid-frame, abandon the partial frame; no frame_valid from pre-reset captures.

Configuration
REQ-023 SHALL compile the timeout watchdog only when SEVEN_SEG_SCAN_TIMEOUT_EN is defined.
REQ-024 SHALL, with the macro, count cycles since the last frame_valid (saturating), assert stale when the count reaches TIMEOUT_CYCLES, clear stale and counter on frame_valid.
REQ-025 SHALL, without the macro, tie stale to 0 and instantiate no timeout counter.

Structure
REQ-026 SHALL place the FSM state encoding, the 16-entry segment-pattern table, and the anode index constants in package seven_seg_pkg, shared with the existing segment decoder.
REQ-027 SHALL implement the pattern-to-hex lookup as sub-module seg_pattern_decoder (combinational, 7-bit in, 4-bit value plus valid out).

Verification
REQ-028 SHALL cover: scan "1","2","3","4" on an3..an0 each held 10 cycles -> one frame_valid, char1..char4 = 1,2,3,4.
REQ-029 SHALL cover: digit held 3 cycles with SETTLE_CYCLES=4 -> no capture, no frame_valid.
REQ-030 SHALL cover: an2 and an1 low together -> single anode_err pulse, state BLANK.
REQ-031 SHALL cover: segment pattern 7'b0110110 (invalid) on an0 for 10 cycles -> one seg_err pulse, an0 not marked seen.
REQ-032 SHALL cover: with SEVEN_SEG_SCAN_TIMEOUT_EN, TIMEOUT_CYCLES=16, no scanning -> stale=1 at cycle 16; full frame -> stale=0 with frame_valid.
REQ-033 SHALL cover: reset asserted after three digits captured, then fourth digit scanned -> no frame_valid, outputs remain 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan decoder and the segment decoder.
// Segment patterns are {a,b,c,d,e,f,g} active-low; anode index k corresponds to port an<k>.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_BLANK    = 2'd0,
        ST_SETTLING = 2'd1,
        ST_HELD     = 2'd2
    } scanState_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [1:0] IDX_AN0 = 2'd0;
    localparam logic [1:0] IDX_AN1 = 2'd1;
    localparam logic [1:0] IDX_AN2 = 2'd2;
    localparam logic [1:0] IDX_AN3 = 2'd3;

    // Entry i is the active-low pattern that displays hex digit i (0-9, A, b, C, d, E, F).
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_pattern_decoder.sv
// Combinational lookup of an active-low 7-segment pattern into its hex value.
// Patterns outside the table report o_valid = 0 and value 0.
module seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_valid
);

    always_comb begin
        o_value = 4'h0;
        o_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == SEG_TABLE[i]) begin
                o_value = 4'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers four hex characters by observing a multiplexed 7-segment display scan.
// Define SEVEN_SEG_SCAN_TIMEOUT_EN to build the stale-frame watchdog; otherwise stale is tied low.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       led_a,
    input  logic       led_b,
    input  logic       led_c,
    input  logic       led_d,
    input  logic       led_e,
    input  logic       led_f,
    input  logic       led_g,
    input  logic       dp,
    output logic [3:0] char1,
    output logic [3:0] char2,
    output logic [3:0] char3,
    output logic [3:0] char4,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       anode_err,
    output logic       stale
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    scanState_t       r_state;
    scanState_t       w_stateNext;
    logic [7:0]       r_settleCnt;
    logic [7:0]       w_settleCntNext;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic [10:0]      r_vecPrev;
    logic             r_multiPrev;
    logic [3:0]       r_seen;
    logic [3:0]       w_seenNext;
    logic [3:0][3:0]  r_shadow;
    logic [3:0][3:0]  r_char;
    logic             r_frameValid;
    logic             r_segErr;
    logic             r_anodeErr;
    logic             w_changed;
    logic             w_noneLow;
    logic             w_oneLow;
    logic             w_multiLow;
    logic [1:0]       w_digitIdx;
    logic             w_capture;
    logic             w_frameDone;
    logic [3:0]       w_segValue;
    logic             w_segValid;
    logic             w_unusedDp;

    assign w_unusedDp = dp;

    // Inputs are registered once; every decision below works on this copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an      <= 4'hF;
            r_seg     <= 7'h7F;
            r_vecPrev <= 11'h7FF;
        end else begin
            r_an      <= {an3, an2, an1, an0};
            r_seg     <= {led_a, led_b, led_c, led_d, led_e, led_f, led_g};
            r_vecPrev <= {r_an, r_seg};
        end
    end

    assign w_changed  = ({r_an, r_seg} != r_vecPrev);
    assign w_noneLow  = (r_an == 4'hF);
    assign w_oneLow   = ($countones(~r_an) == 1);
    assign w_multiLow = !w_noneLow && !w_oneLow;

    always_comb begin
        w_digitIdx = IDX_AN0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!r_an[k]) w_digitIdx = 2'(k);
        end
    end

    seg_pattern_decoder u_segDecoder (
        .i_pattern (r_seg),
        .o_value   (w_segValue),
        .o_valid   (w_segValid)
    );

    // A digit is captured once its vector has repeated SETTLE_CYCLES times after the first sample.
    always_comb begin
        w_stateNext     = r_state;
        w_settleCntNext = r_settleCnt;
        w_capture       = 1'b0;
        unique case (r_state)
            ST_BLANK: begin
                if (w_oneLow) begin
                    w_stateNext     = ST_SETTLING;
                    w_settleCntNext = 8'd0;
                end
            end
            ST_SETTLING: begin
                if (w_changed) begin
                    w_stateNext     = w_oneLow ? ST_SETTLING : ST_BLANK;
                    w_settleCntNext = 8'd0;
                end else if (r_settleCnt == SETTLE_LAST) begin
                    w_stateNext = ST_HELD;
                    w_capture   = 1'b1;
                end else begin
                    w_settleCntNext = r_settleCnt + 8'd1;
                end
            end
            ST_HELD: begin
                if (w_changed) begin
                    w_stateNext     = w_oneLow ? ST_SETTLING : ST_BLANK;
                    w_settleCntNext = 8'd0;
                end
            end
            default: begin
                w_stateNext     = ST_BLANK;
                w_settleCntNext = 8'd0;
            end
        endcase
    end

    assign w_frameDone = &r_seen;
    assign w_seenNext  = (w_frameDone ? 4'h0 : r_seen) |
                         ((w_capture && w_segValid) ? (4'b0001 << w_digitIdx) : 4'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_settleCnt  <= 8'd0;
            r_multiPrev  <= 1'b0;
            r_seen       <= 4'h0;
            r_shadow     <= '0;
            r_char       <= '0;
            r_frameValid <= 1'b0;
            r_segErr     <= 1'b0;
            r_anodeErr   <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_settleCnt  <= w_settleCntNext;
            r_multiPrev  <= w_multiLow;
            r_anodeErr   <= w_multiLow && !r_multiPrev;
            r_segErr     <= w_capture && !w_segValid;
            r_frameValid <= w_frameDone;
            r_seen       <= w_seenNext;
            if (w_frameDone) r_char <= r_shadow;
            if (w_capture && w_segValid) r_shadow[w_digitIdx] <= w_segValue;
        end
    end

    assign char1       = r_char[IDX_AN3];
    assign char2       = r_char[IDX_AN2];
    assign char3       = r_char[IDX_AN1];
    assign char4       = r_char[IDX_AN0];
    assign frame_valid = r_frameValid;
    assign seg_err     = r_segErr;
    assign anode_err   = r_anodeErr;

`ifdef SEVEN_SEG_SCAN_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_toCnt;
    logic            r_stale;

    // Saturating count of cycles since the last completed frame.
    always_ff @(posedge clk) begin
        if (reset || w_frameDone) begin
            r_toCnt <= '0;
            r_stale <= 1'b0;
        end else if (r_toCnt != TO_MAX) begin
            r_toCnt <= r_toCnt + 1'b1;
            r_stale <= (r_toCnt == TO_LAST);
        end
    end

    assign stale = r_stale;
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Randomized and directed bench for seven_seg_scan_decoder with a step-level scan model.
// Timeout checks are built when SEVEN_SEG_SCAN_TIMEOUT_EN is defined.
module tb_seven_seg_scan_decoder;

    localparam int SETTLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       an3 = 1'b1, an2 = 1'b1, an1 = 1'b1, an0 = 1'b1;
    logic       led_a = 1'b1, led_b = 1'b1, led_c = 1'b1, led_d = 1'b1;
    logic       led_e = 1'b1, led_f = 1'b1, led_g = 1'b1, dp = 1'b1;
    logic [3:0] char1, char2, char3, char4;
    logic       frame_valid, seg_err, anode_err, stale;

    int checks   = 0;
    int failures = 0;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an3         (an3),
        .an2         (an2),
        .an1         (an1),
        .an0         (an0),
        .led_a       (led_a),
        .led_b       (led_b),
        .led_c       (led_c),
        .led_d       (led_d),
        .led_e       (led_e),
        .led_f       (led_f),
        .led_g       (led_g),
        .dp          (dp),
        .char1       (char1),
        .char2       (char2),
        .char3       (char3),
        .char4       (char4),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .anode_err   (anode_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    // Lit segments per hex digit, as drawn on a display.
    string litSegs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Observed DUT events, recorded on the falling edge.
    logic [15:0] obsFrames [$];
    int          obsSegErr = 0;
    int          obsAnErr  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) obsFrames.push_back({char1, char2, char3, char4});
            if (seg_err)     obsSegErr++;
            if (anode_err)   obsAnErr++;
        end
    end

    // Reference model state: one update per stimulus step.
    logic [3:0]  mShadow [4];
    logic [3:0]  mSeen;
    logic [15:0] mChars;
    bit          mMultiPrev;
    logic [15:0] expFrames [$];
    int          mSegErr = 0;
    int          mAnErr  = 0;

    function automatic logic [6:0] segPattern(input string lit);
        logic [6:0] p;
        p = 7'h7F;
        for (int i = 0; i < lit.len(); i++) p[6 - int'(lit[i] - "a")] = 1'b0;
        return p;
    endfunction

    function automatic logic [6:0] digitPattern(input int v);
        return segPattern(litSegs[v]);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) mShadow[i] = 4'h0;
        mSeen      = 4'h0;
        mChars     = 16'h0;
        mMultiPrev = 1'b0;
    endfunction

    function automatic void modelStep(input logic [3:0] an, input logic [6:0] seg, input int len);
        int lows;
        int idx;
        int val;
        lows = 0;
        idx  = 0;
        val  = -1;
        for (int k = 0; k < 4; k++) if (!an[k]) begin lows++; idx = k; end
        if (lows > 1) begin
            if (!mMultiPrev) mAnErr++;
            mMultiPrev = 1'b1;
            return;
        end
        mMultiPrev = 1'b0;
        if (lows == 1 && len >= SETTLE_CYCLES + 1) begin
            for (int v = 0; v < 16; v++) if (digitPattern(v) == seg) val = v;
            if (val < 0) begin
                mSegErr++;
            end else begin
                mShadow[idx] = 4'(val);
                mSeen[idx]   = 1'b1;
                if (mSeen == 4'hF) begin
                    mChars = {mShadow[3], mShadow[2], mShadow[1], mShadow[0]};
                    expFrames.push_back(mChars);
                    mSeen = 4'h0;
                end
            end
        end
    endfunction

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int len);
        {an3, an2, an1, an0} = an;
        {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = seg;
        dp = 1'($urandom);
        repeat (len) @(posedge clk);
        #1;
        modelStep(an, seg, len);
    endtask

    task automatic doReset();
        reset = 1'b1;
        {an3, an2, an1, an0} = 4'hF;
        {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = 7'h7F;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {an3, an2, an1, an0} = 4'($urandom);
        {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = 7'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({char1, char2, char3, char4} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_chars: got %h expected 0000", {char1, char2, char3, char4});
        end
        checks++;
        if ({frame_valid, seg_err, anode_err} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_pulses: got %b expected 000", {frame_valid, seg_err, anode_err});
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stale: got %b expected 0", stale);
        end
        doReset();
    endtask

    task automatic test_basic_scan();
        int fBase;
        doReset();
        fBase = obsFrames.size();
        applyStimulus(4'b0111, digitPattern(1), 10);
        applyStimulus(4'b1011, digitPattern(2), 10);
        applyStimulus(4'b1101, digitPattern(3), 10);
        applyStimulus(4'b1110, digitPattern(4), 10);
        applyStimulus(4'hF, 7'h7F, 6);
        checks++;
        if (obsFrames.size() - fBase !== 1) begin
            failures++;
            $display("[TB] FAIL basic_frame_count: got %0d expected 1", obsFrames.size() - fBase);
        end
        if (obsFrames.size() > fBase) begin
            checks++;
            if (obsFrames[fBase] !== 16'h1234) begin
                failures++;
                $display("[TB] FAIL basic_frame_value: got %h expected 1234", obsFrames[fBase]);
            end
        end
        checks++;
        if ({char1, char2, char3, char4} !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL basic_chars_hold: got %h expected 1234", {char1, char2, char3, char4});
        end
    endtask

    task automatic test_short_hold();
        int fBase;
        doReset();
        fBase = obsFrames.size();
        applyStimulus(4'b1110, digitPattern(7), 3);
        applyStimulus(4'hF, 7'h7F, 2);
        applyStimulus(4'b1110, digitPattern(7), SETTLE_CYCLES);
        applyStimulus(4'hF, 7'h7F, 2);
        applyStimulus(4'b0111, digitPattern(10), 10);
        applyStimulus(4'b1011, digitPattern(11), 10);
        applyStimulus(4'b1101, digitPattern(12), 10);
        applyStimulus(4'hF, 7'h7F, 6);
        checks++;
        if (obsFrames.size() - fBase !== 0) begin
            failures++;
            $display("[TB] FAIL short_hold_no_frame: got %0d frames expected 0", obsFrames.size() - fBase);
        end
        applyStimulus(4'b1110, digitPattern(7), SETTLE_CYCLES + 1);
        applyStimulus(4'hF, 7'h7F, 6);
        checks++;
        if (obsFrames.size() - fBase !== 1) begin
            failures++;
            $display("[TB] FAIL threshold_frame_count: got %0d expected 1", obsFrames.size() - fBase);
        end else begin
            checks++;
            if (obsFrames[fBase] !== 16'hABC7) begin
                failures++;
                $display("[TB] FAIL threshold_frame_value: got %h expected abc7", obsFrames[fBase]);
            end
        end
    endtask

    task automatic test_anode_err();
        int aBase, mBase, fBase;
        doReset();
        aBase = obsAnErr;
        mBase = mAnErr;
        fBase = obsFrames.size();
        applyStimulus(4'b1001, digitPattern(5), 8);
        applyStimulus(4'hF, 7'h7F, 4);
        checks++;
        if (obsAnErr - aBase !== 1) begin
            failures++;
            $display("[TB] FAIL anode_err_single: got %0d pulses expected 1", obsAnErr - aBase);
        end
        applyStimulus(4'b0111, digitPattern(1), 10);
        applyStimulus(4'b0110, digitPattern(1), 6);
        applyStimulus(4'b0000, digitPattern(1), 4);
        applyStimulus(4'hF, 7'h7F, 3);
        applyStimulus(4'b1100, digitPattern(2), 3);
        applyStimulus(4'hF, 7'h7F, 4);
        checks++;
        if (obsAnErr - aBase !== mAnErr - mBase) begin
            failures++;
            $display("[TB] FAIL anode_err_entries: got %0d pulses expected %0d", obsAnErr - aBase, mAnErr - mBase);
        end
        checks++;
        if (obsFrames.size() - fBase !== 0) begin
            failures++;
            $display("[TB] FAIL anode_err_no_frame: got %0d frames expected 0", obsFrames.size() - fBase);
        end
    endtask

    task automatic test_seg_err();
        int sBase, fBase;
        doReset();
        sBase = obsSegErr;
        fBase = obsFrames.size();
        applyStimulus(4'b1110, 7'b0110110, 10);
        applyStimulus(4'hF, 7'h7F, 4);
        checks++;
        if (obsSegErr - sBase !== 1) begin
            failures++;
            $display("[TB] FAIL seg_err_single: got %0d pulses expected 1", obsSegErr - sBase);
        end
        applyStimulus(4'b0111, digitPattern(6), 10);
        applyStimulus(4'b1011, digitPattern(13), 10);
        applyStimulus(4'b1101, digitPattern(14), 10);
        applyStimulus(4'hF, 7'h7F, 6);
        checks++;
        if (obsFrames.size() - fBase !== 0) begin
            failures++;
            $display("[TB] FAIL seg_err_not_seen: got %0d frames expected 0", obsFrames.size() - fBase);
        end
        applyStimulus(4'b1110, digitPattern(9), 10);
        applyStimulus(4'hF, 7'h7F, 6);
        checks++;
        if (obsFrames.size() - fBase !== 1) begin
            failures++;
            $display("[TB] FAIL seg_err_recover_count: got %0d expected 1", obsFrames.size() - fBase);
        end else begin
            checks++;
            if (obsFrames[fBase] !== 16'h6DE9) begin
                failures++;
                $display("[TB] FAIL seg_err_recover_value: got %h expected 6de9", obsFrames[fBase]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int fBase;
        doReset();
        fBase = obsFrames.size();
        applyStimulus(4'b0111, digitPattern(1), 10);
        applyStimulus(4'b1011, digitPattern(2), 10);
        applyStimulus(4'b1101, digitPattern(3), 10);
        doReset();
        applyStimulus(4'b1110, digitPattern(4), 10);
        applyStimulus(4'hF, 7'h7F, 8);
        checks++;
        if (obsFrames.size() - fBase !== 0) begin
            failures++;
            $display("[TB] FAIL reset_midframe_no_frame: got %0d frames expected 0", obsFrames.size() - fBase);
        end
        checks++;
        if ({char1, char2, char3, char4} !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_midframe_chars: got %h expected 0000", {char1, char2, char3, char4});
        end
    endtask

    task automatic test_random();
        int          fBase, eBase, sBase, msBase, aBase, maBase, nObs, nExp;
        logic [3:0]  an, prevAn;
        logic [6:0]  seg, prevSeg;
        int          sel;
        doReset();
        fBase  = obsFrames.size();
        eBase  = expFrames.size();
        sBase  = obsSegErr;
        msBase = mSegErr;
        aBase  = obsAnErr;
        maBase = mAnErr;
        prevAn  = 4'hF;
        prevSeg = 7'h7F;
        for (int step = 0; step < 120; step++) begin
            do begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0) an = 4'hF;
                else if (sel == 1) begin
                    do an = 4'($urandom); while ($countones(~an) < 2);
                end else an = ~(4'b0001 << $urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) seg = 7'($urandom);
                else seg = digitPattern(int'($urandom_range(0, 15)));
            end while ({an, seg} == {prevAn, prevSeg});
            applyStimulus(an, seg, int'($urandom_range(1, 8)));
            prevAn  = an;
            prevSeg = seg;
        end
        applyStimulus(4'hF, 7'h7F, 8);
        nObs = obsFrames.size() - fBase;
        nExp = expFrames.size() - eBase;
        checks++;
        if (nObs !== nExp) begin
            failures++;
            $display("[TB] FAIL random_frame_count: got %0d expected %0d", nObs, nExp);
        end
        for (int i = 0; i < nObs && i < nExp; i++) begin
            checks++;
            if (obsFrames[fBase + i] !== expFrames[eBase + i]) begin
                failures++;
                $display("[TB] FAIL random_frame_%0d: got %h expected %h", i, obsFrames[fBase + i], expFrames[eBase + i]);
            end
        end
        checks++;
        if (obsSegErr - sBase !== mSegErr - msBase) begin
            failures++;
            $display("[TB] FAIL random_seg_err: got %0d expected %0d", obsSegErr - sBase, mSegErr - msBase);
        end
        checks++;
        if (obsAnErr - aBase !== mAnErr - maBase) begin
            failures++;
            $display("[TB] FAIL random_anode_err: got %0d expected %0d", obsAnErr - aBase, mAnErr - maBase);
        end
        checks++;
        if ({char1, char2, char3, char4} !== mChars) begin
            failures++;
            $display("[TB] FAIL random_chars: got %h expected %h", {char1, char2, char3, char4}, mChars);
        end
    endtask

`ifdef SEVEN_SEG_SCAN_TIMEOUT_EN
    task automatic test_timeout();
        bit gotFrame;
        doReset();
        repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stale_early: got %b expected 0", stale);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (stale !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stale_at_limit: got %b expected 1", stale);
        end
        @(posedge clk);
        #1;
        applyStimulus(4'b0111, digitPattern(1), 10);
        applyStimulus(4'b1011, digitPattern(2), 10);
        applyStimulus(4'b1101, digitPattern(3), 10);
        {an3, an2, an1, an0} = 4'b1110;
        {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = digitPattern(4);
        gotFrame = 1'b0;
        for (int i = 0; i < 30 && !gotFrame; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                gotFrame = 1'b1;
                checks++;
                if (stale !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stale_clear: got %b expected 0", stale);
                end
            end
        end
        checks++;
        if (!gotFrame) begin
            failures++;
            $display("[TB] FAIL stale_frame_wait: got no frame_valid expected one within 30 cycles");
        end
        @(posedge clk);
        #1;
        modelStep(4'b1110, digitPattern(4), 10);
        applyStimulus(4'hF, 7'h7F, 4);
    endtask
`else
    task automatic test_timeout();
        doReset();
        applyStimulus(4'hF, 7'h7F, 3 * TIMEOUT_CYCLES);
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stale_tied_low: got %b expected 0", stale);
        end
    endtask
`endif

    initial begin
        $display("[TB] starting seven_seg_scan_decoder bench");
        modelReset();
        test_reset();
        test_basic_scan();
        test_short_hold();
        test_anode_err();
        test_seg_err();
        test_reset_midframe();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
